// File: rtl/bs_dot_sequencer.sv
// bs_dot_sequencer: operand-side driver for the back-substitution MAC.
// For one requested row it streams R[row][j] / x[j] pairs (j = row+1..N-1)
// into the MAC, waits out the memory and multiplier pipelines, then returns
// the captured accumulator over a valid/ready result port.
module bs_dot_sequencer #(
    parameter int unsigned DW      = 16,
    parameter int unsigned N       = 8,
    parameter int unsigned AW      = $clog2(N),
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AW:0]              row,
    output logic                     busy,
    output logic                     r_rd_en,
    output logic [$clog2(N*N)-1:0]   r_rd_addr,
    input  logic [DW-1:0]            r_rd_data,
    output logic                     x_rd_en,
    output logic [AW-1:0]            x_rd_addr,
    input  logic [DW-1:0]            x_rd_data,
    output logic                     mac_en,
    output logic                     mac_clear,
    output logic [DW-1:0]            mac_din1,
    output logic [DW-1:0]            mac_din2,
    input  logic [DW-1:0]            mac_dout,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DW-1:0]            res_data,
    output logic [AW:0]              res_row
);

    localparam int unsigned RAW = $clog2(N*N);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned D   = MEM_LAT + MUL_LAT + 1;
    localparam int unsigned DCW = $clog2(D + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_k;
    logic [CW-1:0]        r_col;
    logic [DCW-1:0]       r_dcnt;
    logic [MEM_LAT-1:0]   r_mac_sr;

    state_t               w_nxt_state;
    logic [CW-1:0]        w_nxt_k;
    logic [CW-1:0]        w_nxt_col;
    logic [DCW-1:0]       w_nxt_dcnt;
    logic                 w_nxt_busy;
    logic                 w_nxt_rd_en;
    logic [RAW-1:0]       w_nxt_r_addr;
    logic [AW-1:0]        w_nxt_x_addr;
    logic                 w_nxt_clear;
    logic                 w_nxt_valid;
    logic [DW-1:0]        w_nxt_res_data;
    logic [AW:0]          w_nxt_res_row;
    logic [CW-1:0]        w_k_init;
    logic [RAW-1:0]       w_r_addr;

    // Operands go straight from the memories to the MAC; mac_en does the gating.
    assign mac_din1 = r_rd_data;
    assign mac_din2 = x_rd_data;
    assign mac_en   = r_mac_sr[MEM_LAT-1];

    // Number of products for a row: zero for the last row and out-of-range rows.
    assign w_k_init = (row >= CW'(N - 1)) ? '0 : (CW'(N - 1) - row);

    // R is stored row-major; res_row holds the active row while issuing.
    assign w_r_addr = RAW'(res_row) * RAW'(N) + RAW'(r_col);

    // Next-state and next-output decode; all outputs are registered from these.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_k        = r_k;
        w_nxt_col      = r_col;
        w_nxt_dcnt     = r_dcnt;
        w_nxt_busy     = 1'b1;
        w_nxt_rd_en    = 1'b0;
        w_nxt_r_addr   = r_rd_addr;
        w_nxt_x_addr   = x_rd_addr;
        w_nxt_clear    = 1'b0;
        w_nxt_valid    = 1'b0;
        w_nxt_res_data = res_data;
        w_nxt_res_row  = res_row;
        case (r_state)
            S_IDLE: begin
                w_nxt_busy = 1'b0;
                if (start) begin
                    w_nxt_state   = S_CLEAR;
                    w_nxt_busy    = 1'b1;
                    w_nxt_clear   = 1'b1;
                    w_nxt_res_row = row;
                    w_nxt_k       = w_k_init;
                    w_nxt_col     = row + CW'(1);
                end
            end
            S_CLEAR, S_ISSUE: begin
                if (r_k != '0) begin
                    w_nxt_state  = S_ISSUE;
                    w_nxt_rd_en  = 1'b1;
                    w_nxt_r_addr = w_r_addr;
                    w_nxt_x_addr = r_col[AW-1:0];
                    w_nxt_col    = r_col + CW'(1);
                    w_nxt_k      = r_k - CW'(1);
                end else begin
                    w_nxt_state = S_DRAIN;
                    w_nxt_dcnt  = DCW'(D - 1);
                end
            end
            S_DRAIN: begin
                if (r_dcnt == '0) begin
                    w_nxt_state    = S_HOLD;
                    w_nxt_valid    = 1'b1;
                    w_nxt_res_data = mac_dout;
                end else begin
                    w_nxt_dcnt = r_dcnt - DCW'(1);
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_busy  = 1'b0;
                end else begin
                    w_nxt_valid = 1'b1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_busy  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_col     <= '0;
            r_dcnt    <= '0;
            busy      <= 1'b0;
            r_rd_en   <= 1'b0;
            x_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            x_rd_addr <= '0;
            mac_clear <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_row   <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_k       <= w_nxt_k;
            r_col     <= w_nxt_col;
            r_dcnt    <= w_nxt_dcnt;
            busy      <= w_nxt_busy;
            r_rd_en   <= w_nxt_rd_en;
            x_rd_en   <= w_nxt_rd_en;
            r_rd_addr <= w_nxt_r_addr;
            x_rd_addr <= w_nxt_x_addr;
            mac_clear <= w_nxt_clear;
            res_valid <= w_nxt_valid;
            res_data  <= w_nxt_res_data;
            res_row   <= w_nxt_res_row;
        end
    end

    // Delay the read strobe by the memory latency so mac_en lines up with data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mac_sr <= '0;
        end else begin
            r_mac_sr <= MEM_LAT'({r_mac_sr, r_rd_en});
        end
    end

endmodule
